// File: rtl/spi_flash_write_sequencer_pkg.sv
// Shared types and constants for the SPI flash write sequencer.
package flash_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRECHECK,
    SET_ADDR,
    SEND_DATA,
    START,
    WAIT,
    POLL,
    REPORT
  } state_t;

  // Custom-instruction selectors carried on ciDataB
  localparam logic [31:0] SEL_STATUS = 32'h0000_0007;
  localparam logic [31:0] SEL_ADDR   = 32'h0000_0016;
  localparam logic [31:0] SEL_DATA0  = 32'h0000_0018;

  // Operation codes written with SEL_STATUS to launch an operation
  localparam logic [31:0] OP_PROGRAM = 32'd1;
  localparam logic [31:0] OP_ERASE   = 32'd2;

  // Bit positions in the flash status word (ciResult)
  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_WRITE_ERR = 1;
  localparam int unsigned ST_ERASE_ERR = 2;

  // resultStatus encoding {timeout, eraseError, writeError}
  localparam logic [2:0] RES_TIMEOUT = 3'b100;

endpackage

// File: rtl/spi_flash_write_sequencer_if.sv
// Custom-instruction bus between the sequencer (master) and the flash controller (slave).
interface spi_flash_write_sequencer_if;
  logic [7:0]  ciN;
  logic [31:0] ciDataA;
  logic [31:0] ciDataB;
  logic        ciStart;
  logic        ciCke;
  logic        ciDone;
  logic [31:0] ciResult;

  modport master (
    output ciN, ciDataA, ciDataB, ciStart, ciCke,
    input  ciDone, ciResult
  );

  modport slave (
    input  ciN, ciDataA, ciDataB, ciStart, ciCke,
    output ciDone, ciResult
  );
endinterface

// File: rtl/spi_flash_write_sequencer_ci_master_port.sv
// Custom-instruction master port: registers the operands and holds the
// request on the bus until the controller answers with ciDone.
module ci_master_port #(
  parameter logic [7:0] customInstructionNr = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] sel,
  input  logic [31:0] data_a,
  output logic        ack,
  output logic [31:0] result,
  spi_flash_write_sequencer_if.master ci
);

  logic        start_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  assign ci.ciN     = customInstructionNr;
  assign ci.ciStart = start_q;
  assign ci.ciCke   = start_q;
  assign ci.ciDataA = a_q;
  assign ci.ciDataB = b_q;

  // ack and result are combinational so the FSM can advance in the done
  // cycle; start drops on the following edge, leaving a one-cycle gap.
  assign ack    = start_q & ci.ciDone;
  assign result = ci.ciResult;

  // Launch a transfer when idle, hold it until ciDone is seen
  always_ff @(posedge clock) begin
    if (!reset) begin
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (start_q) begin
      if (ci.ciDone) start_q <= 1'b0;
    end else if (req) begin
      start_q <= 1'b1;
      a_q     <= data_a;
      b_q     <= sel;
    end
  end

endmodule

// File: rtl/spi_flash_write_sequencer.sv
// Sequences page-program and sector-erase operations over the flash
// controller's custom-instruction port from a single requester command.
module spi_flash_write_sequencer
  import flash_seq_pkg::*;
#(
  parameter logic [7:0]  customInstructionNr = 8'd0,
  parameter int unsigned pollInterval        = 16,
  parameter logic [31:0] maxPolls            = 32'd1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dataWe,
  input  logic [2:0]  dataIndex,
  input  logic [31:0] dataIn,
  input  logic        cmdValid,
  input  logic        cmdErase,
  input  logic [23:0] cmdAddress,
  output logic        cmdReady,
  output logic        resultValid,
  output logic [2:0]  resultStatus,
  spi_flash_write_sequencer_if.master ci
);

  localparam logic [31:0] WAIT_LAST = 32'(pollInterval - 1);

  state_t      state, next_state;
  logic [31:0] buffer [8];
  logic [2:0]  idx;
  logic [31:0] poll_cnt;
  logic [31:0] wait_cnt;
  logic        from_precheck;
  logic        erase_q;
  logic [23:0] addr_q;
  logic [2:0]  status_q;

  logic        ci_req;
  logic [31:0] ci_sel;
  logic [31:0] ci_a;
  logic        ci_ack;
  logic [31:0] ci_result;
  logic        busy;
  logic [31:0] poll_next;
  logic        timeout;
  logic        unused_result_bits;

  ci_master_port #(.customInstructionNr(customInstructionNr)) u_port (
    .clock  (clock),
    .reset  (reset),
    .req    (ci_req),
    .sel    (ci_sel),
    .data_a (ci_a),
    .ack    (ci_ack),
    .result (ci_result),
    .ci     (ci)
  );

  assign busy               = ci_result[ST_BUSY];
  assign poll_next          = (poll_cnt == '1) ? poll_cnt : poll_cnt + 32'd1;
  assign timeout            = (poll_next >= maxPolls);
  assign unused_result_bits = ^ci_result[31:3];

  assign cmdReady     = (state == IDLE);
  assign resultValid  = (state == REPORT);
  assign resultStatus = status_q;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode and CI request generation
  always_comb begin
    next_state = state;
    ci_req     = 1'b0;
    ci_sel     = SEL_STATUS;
    ci_a       = '0;
    case (state)
      IDLE: begin
        if (cmdValid) next_state = PRECHECK;
      end
      PRECHECK: begin
        ci_req = 1'b1;
        if (ci_ack) begin
          if (!busy)        next_state = SET_ADDR;
          else if (timeout) next_state = REPORT;
          else              next_state = WAIT;
        end
      end
      SET_ADDR: begin
        ci_req = 1'b1;
        ci_sel = SEL_ADDR;
        ci_a   = {8'd0, addr_q};
        if (ci_ack) next_state = erase_q ? START : SEND_DATA;
      end
      SEND_DATA: begin
        ci_req = 1'b1;
        ci_sel = SEL_DATA0 + {29'd0, idx};
        ci_a   = buffer[idx];
        if (ci_ack && idx == 3'd7) next_state = START;
      end
      START: begin
        ci_req = 1'b1;
        ci_a   = erase_q ? OP_ERASE : OP_PROGRAM;
        if (ci_ack) next_state = WAIT;
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) next_state = from_precheck ? PRECHECK : POLL;
      end
      POLL: begin
        ci_req = 1'b1;
        if (ci_ack) begin
          if (!busy || timeout) next_state = REPORT;
          else                  next_state = WAIT;
        end
      end
      REPORT: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Buffer, command latch, counters and result status
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 8; i++) buffer[i] <= '0;
      idx           <= '0;
      poll_cnt      <= '0;
      wait_cnt      <= '0;
      from_precheck <= 1'b0;
      erase_q       <= 1'b0;
      addr_q        <= '0;
      status_q      <= '0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 32'd1 : '0;
      case (state)
        IDLE: begin
          if (dataWe) buffer[dataIndex] <= dataIn;
          if (cmdValid) begin
            erase_q       <= cmdErase;
            addr_q        <= cmdAddress;
            status_q      <= '0;
            poll_cnt      <= '0;
            idx           <= '0;
            from_precheck <= 1'b1;
          end
        end
        PRECHECK: begin
          if (ci_ack) begin
            poll_cnt <= poll_next;
            if (busy && timeout) status_q <= RES_TIMEOUT;
          end
        end
        SEND_DATA: begin
          if (ci_ack && idx != 3'd7) idx <= idx + 3'd1;
        end
        START: begin
          if (ci_ack) begin
            poll_cnt      <= '0;
            from_precheck <= 1'b0;
          end
        end
        POLL: begin
          if (ci_ack) begin
            poll_cnt <= poll_next;
            if (!busy)        status_q <= {1'b0, ci_result[ST_ERASE_ERR], ci_result[ST_WRITE_ERR]};
            else if (timeout) status_q <= RES_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
